// File: rtl/memory_sdp.sv
// Simple-dual-port synchronous memory with byte-enabled writes, 1-cycle write-first reads and a post-reset fill sweep.
// Optional per-byte even parity storage and checking is enabled by defining MEMORY_SDP_PARITY_EN.
module memory_sdp #(
    parameter int          ADDR_WIDTH = 4,
    parameter int          DATA_WIDTH = 8,
    parameter logic [7:0]  INIT_BYTE  = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rd_valid,
    output logic                    init_busy,
    output logic                    acc_drop,
    output logic                    rd_perr
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] FILL_WORD = {NB{INIT_BYTE}};

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_width_check
        $error("memory_sdp: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {INIT, READY} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   init_cnt, init_cnt_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_go, rd_go, collide;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        if (state == INIT) begin
            init_cnt_next = init_cnt + 1'b1;
            if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                state_next = READY;
            end
        end
    end

    assign init_busy = (state == INIT);
    assign wr_go     = wr_en && !init_busy;
    assign rd_go     = rd_en && !init_busy;
    assign collide   = wr_go && rd_go && (wr_addr == rd_addr);

    // Write-first: on a collision the new bytes replace the stale ones on the read path.
    always_comb begin
        rd_word = mem[rd_addr];
        if (collide) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[init_cnt] <= FILL_WORD;
        end else if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
            acc_drop <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            acc_drop <= init_busy && (wr_en || rd_en);
            if (rd_go) rdata <= rd_word;
        end
    end

`ifdef MEMORY_SDP_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] fill_par, wr_par, rd_par;
    logic          perr_now;

    always_comb begin
        fill_par = '0;
        wr_par   = '0;
        rd_par   = '0;
        for (int i = 0; i < NB; i++) begin
            fill_par[i] = ^INIT_BYTE;
            wr_par[i]   = ^wdata[8*i +: 8];
            rd_par[i]   = ^mem[rd_addr][8*i +: 8];
        end
    end

    assign perr_now = |(rd_par ^ par_mem[rd_addr]);

    always_ff @(posedge clk) begin
        if (init_busy) begin
            par_mem[init_cnt] <= fill_par;
        end else if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) par_mem[wr_addr][i] <= wr_par[i];
            end
        end
    end

    // Bypassed collision data never came out of the array, so it cannot carry a parity fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_perr <= 1'b0;
        else       rd_perr <= rd_go && !collide && perr_now;
    end
`else
    assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_memory_sdp.sv
// Directed bench for memory_sdp: an 8-bit instance for the main behaviour and a 32-bit instance for byte enables.
module tb_memory_sdp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [3:0]  wr_addr = '0, rd_addr = '0;
    logic [0:0]  wr_be = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        rd_valid, init_busy, acc_drop, rd_perr;

    logic        wr_en32 = 1'b0, rd_en32 = 1'b0;
    logic [3:0]  wr_addr32 = '0, rd_addr32 = '0;
    logic [3:0]  wr_be32 = '0;
    logic [31:0] wdata32 = '0;
    logic [31:0] rdata32;
    logic        rd_valid32, init_busy32, acc_drop32, rd_perr32;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    memory_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .INIT_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata),
        .rd_valid(rd_valid), .init_busy(init_busy), .acc_drop(acc_drop), .rd_perr(rd_perr)
    );

    memory_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .INIT_BYTE(8'hFF)) dut32 (
        .clk(clk), .reset(reset), .wr_en(wr_en32), .wr_addr(wr_addr32), .wr_be(wr_be32),
        .wdata(wdata32), .rd_en(rd_en32), .rd_addr(rd_addr32), .rdata(rdata32),
        .rd_valid(rd_valid32), .init_busy(init_busy32), .acc_drop(acc_drop32), .rd_perr(rd_perr32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
        wr_en32 = 1'b0; rd_en32 = 1'b0; wr_be32 = '0;
    endtask

    // Counts edges until init_busy falls; optionally holds requests high to exercise the drop path.
    task automatic sweep(input bit hammer, output int cycles);
        cycles = 0;
        wr_en = hammer; rd_en = hammer; wr_addr = 4'd4; rd_addr = 4'd4;
        wr_be = 1'b1; wdata = 8'h00;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (hammer) begin
                check("acc_drop_sweep", acc_drop, 1'b1);
                check("rd_valid_sweep", rd_valid, 1'b0);
            end
            if (!init_busy) break;
        end
        idle_inputs();
    endtask

    task automatic read8(input logic [3:0] a, input logic [7:0] exp, input string tag);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, 1'b1);
        check(tag, rdata, exp);
    endtask

    task automatic write8(input logic [3:0] a, input logic [7:0] d, input logic be);
        wr_en = 1'b1; wr_addr = a; wdata = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy", init_busy, 1'b1);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        tick();
        tick();
        check("rst_rdata0", rdata, 8'h00);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_drop", acc_drop, 1'b0);
        check("rst_perr", rd_perr, 1'b0);
        check("rst_busy0", init_busy, 1'b1);
        reset = 1'b0;

        // First sweep with requests held high: every cycle drops, nothing is written.
        sweep(1'b1, busy_cycles);
        check("sweep_cycles", busy_cycles, 16);
        check("busy32_done", init_busy32, 1'b0);
        tick();
        check("acc_drop_after", acc_drop, 1'b0);
        check("rd_valid_idle", rd_valid, 1'b0);

        read8(4'd7, 8'hFF, "rd7");
        tick();
        check("rd_valid_pulse", rd_valid, 1'b0);
        check("rdata_hold", rdata, 8'hFF);
        read8(4'd4, 8'hFF, "rd4_untouched");

        // Write-first collision, then a plain re-read.
        wr_en = 1'b1; wr_addr = 4'd5; wdata = 8'h3C; wr_be = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        idle_inputs();
        check("coll_valid", rd_valid, 1'b1);
        check("coll_rdata", rdata, 8'h3C);
        read8(4'd5, 8'h3C, "rd5_after");

        write8(4'd6, 8'h00, 1'b0);
        read8(4'd6, 8'hFF, "be0_noop");

        // Independent ports on different addresses.
        wr_en = 1'b1; wr_addr = 4'd9; wdata = 8'h5A; wr_be = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        idle_inputs();
        check("diff_rdata", rdata, 8'h3C);
        read8(4'd9, 8'h5A, "rd9");

        // Collision with byte disabled returns the old byte.
        wr_en = 1'b1; wr_addr = 4'd9; wdata = 8'h00; wr_be = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd9;
        tick();
        idle_inputs();
        check("coll_be0", rdata, 8'h5A);

        write8(4'd15, 8'hA7, 1'b1);
        read8(4'd15, 8'hA7, "rd15_top");

        // 32-bit byte enables.
        wr_en32 = 1'b1; wr_addr32 = 4'd3; wdata32 = 32'hA1B2C3D4; wr_be32 = 4'b0101;
        tick();
        wr_en32 = 1'b0;
        rd_en32 = 1'b1; rd_addr32 = 4'd3;
        tick();
        rd_en32 = 1'b0;
        check("w32_valid", rd_valid32, 1'b1);
        check("w32_rdata", rdata32, 32'hFFB2FFD4);
        wr_en32 = 1'b1; wr_addr32 = 4'd3; wdata32 = 32'h11223344; wr_be32 = 4'b1000;
        rd_en32 = 1'b1; rd_addr32 = 4'd3;
        tick();
        idle_inputs();
        check("w32_coll", rdata32, 32'h11B2FFD4);

`ifdef MEMORY_SDP_PARITY_EN
        read8(4'd2, 8'hFF, "par_clean");
        check("perr_clean", rd_perr, 1'b0);
        dut.mem[2][0] = ~dut.mem[2][0];
        read8(4'd2, 8'hFE, "par_flip");
        check("perr_flip", rd_perr, 1'b1);
        tick();
        check("perr_pulse", rd_perr, 1'b0);
`else
        check("perr_tied", rd_perr, 1'b0);
`endif

        // Reset after writes, then again mid-sweep at init_cnt=9.
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy", init_busy, 1'b1);
        do_reset();
        sweep(1'b0, busy_cycles);
        check("resweep_cycles", busy_cycles, 16);
        for (int a = 0; a < 16; a++) begin
            read8(4'(a), 8'hFF, $sformatf("refill_%0d", a));
        end
        rd_en32 = 1'b1; rd_addr32 = 4'd3;
        tick();
        rd_en32 = 1'b0;
        check("refill32", rdata32, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
